// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port main memory between the CPU control unit and an external requester.
// Optional fairness guard enabled by defining MEMARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              CpuRead,
    input  logic              CpuWrite,
    input  logic [ADDR_W-1:0] CpuAddr,
    input  logic [DATA_W-1:0] CpuWData,
    output logic [DATA_W-1:0] CpuRData,
    output logic              CpuDone,
    output logic              CpuStall,
    input  logic              ExtReq,
    input  logic              ExtWE,
    input  logic [ADDR_W-1:0] ExtAddr,
    input  logic [DATA_W-1:0] ExtWData,
    output logic [DATA_W-1:0] ExtRData,
    output logic              ExtDone,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              MemRE,
    output logic              MemWE,
    input  logic [DATA_W-1:0] MemRData
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CPU_ACC,
        ST_EXT_ACC,
        ST_CPU_RWAIT,
        ST_EXT_RWAIT
    } state_t;

    // Both counters are 3 bits wide, so the parameters must fit that range.
    if (MEM_LAT < 1 || MEM_LAT > 7 || STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_param
        $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must be in 1..7");
    end

    state_t              r_state,  w_state_nxt;
    logic [CNT_W-1:0]    r_lat_cnt, w_lat_nxt;
    logic [DATA_W-1:0]   r_cpu_rdata, w_cpu_rdata_nxt;
    logic [DATA_W-1:0]   r_ext_rdata, w_ext_rdata_nxt;
    logic                r_cpu_done, w_cpu_done_nxt;
    logic                r_ext_done, w_ext_done_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic                r_mem_re, w_mem_re_nxt;
    logic                r_mem_we, w_mem_we_nxt;
    logic                w_cpu_req;
    logic                w_ext_force;

    assign w_cpu_req = CpuRead | CpuWrite;

`ifdef MEMARB_STARVE_GUARD_EN
    logic [CNT_W-1:0] r_starve_cnt, w_starve_nxt;

    assign w_ext_force = ExtReq && w_cpu_req && (r_starve_cnt == CNT_W'(STARVE_MAX));

    // Counts CPU wins over a waiting Ext requester; any Ext grant or idle Ext clears it.
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (r_state == ST_IDLE) begin
            if (!ExtReq) begin
                w_starve_nxt = '0;
            end else if (w_cpu_req && !w_ext_force) begin
                if (r_starve_cnt != CNT_W'(STARVE_MAX)) begin
                    w_starve_nxt = r_starve_cnt + CNT_W'(1);
                end
            end else begin
                w_starve_nxt = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            r_starve_cnt <= '0;
        end else begin
            r_starve_cnt <= w_starve_nxt;
        end
    end
`else
    assign w_ext_force = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_lat_nxt       = r_lat_cnt;
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_ext_rdata_nxt = r_ext_rdata;
        w_cpu_done_nxt  = 1'b0;
        w_ext_done_nxt  = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_re_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_cpu_req && !w_ext_force) begin
                    w_state_nxt     = ST_CPU_ACC;
                    w_mem_addr_nxt  = CpuAddr;
                    w_mem_wdata_nxt = CpuWData;
                    w_mem_we_nxt    = CpuWrite;
                    w_mem_re_nxt    = ~CpuWrite;
                end else if (ExtReq) begin
                    w_state_nxt     = ST_EXT_ACC;
                    w_mem_addr_nxt  = ExtAddr;
                    w_mem_wdata_nxt = ExtWData;
                    w_mem_we_nxt    = ExtWE;
                    w_mem_re_nxt    = ~ExtWE;
                end
            end
            // The strobe register still tells which kind of access was issued.
            ST_CPU_ACC: begin
                if (r_mem_we) begin
                    w_state_nxt    = ST_IDLE;
                    w_cpu_done_nxt = 1'b1;
                end else begin
                    w_lat_nxt   = CNT_W'(MEM_LAT - 1);
                    w_state_nxt = ST_CPU_RWAIT;
                end
            end
            ST_EXT_ACC: begin
                if (r_mem_we) begin
                    w_state_nxt    = ST_IDLE;
                    w_ext_done_nxt = 1'b1;
                end else begin
                    w_lat_nxt   = CNT_W'(MEM_LAT - 1);
                    w_state_nxt = ST_EXT_RWAIT;
                end
            end
            ST_CPU_RWAIT: begin
                if (r_lat_cnt == '0) begin
                    w_cpu_rdata_nxt = MemRData;
                    w_cpu_done_nxt  = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_lat_nxt = r_lat_cnt - CNT_W'(1);
                end
            end
            ST_EXT_RWAIT: begin
                if (r_lat_cnt == '0) begin
                    w_ext_rdata_nxt = MemRData;
                    w_ext_done_nxt  = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_lat_nxt = r_lat_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            r_state     <= ST_IDLE;
            r_lat_cnt   <= '0;
            r_cpu_rdata <= '0;
            r_ext_rdata <= '0;
            r_cpu_done  <= 1'b0;
            r_ext_done  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lat_cnt   <= w_lat_nxt;
            r_cpu_rdata <= w_cpu_rdata_nxt;
            r_ext_rdata <= w_ext_rdata_nxt;
            r_cpu_done  <= w_cpu_done_nxt;
            r_ext_done  <= w_ext_done_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_re    <= w_mem_re_nxt;
            r_mem_we    <= w_mem_we_nxt;
        end
    end

    assign CpuRData = r_cpu_rdata;
    assign CpuDone  = r_cpu_done;
    assign CpuStall = w_cpu_req & ~r_cpu_done;
    assign ExtRData = r_ext_rdata;
    assign ExtDone  = r_ext_done;
    assign MemAddr  = r_mem_addr;
    assign MemWData = r_mem_wdata;
    assign MemRE    = r_mem_re;
    assign MemWE    = r_mem_we;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one MEM_LAT=1 instance and one MEM_LAT=3 instance.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        Reset_n, rst3_n;
    logic        CpuRead, CpuWrite, ExtReq, ExtWE;
    logic [15:0] CpuAddr, CpuWData, ExtAddr, ExtWData;

    logic [15:0] CpuRData, ExtRData, MemAddr, MemWData, mem_rdata;
    logic        CpuDone, CpuStall, ExtDone, MemRE, MemWE;
    logic [15:0] CpuRData3, ExtRData3, MemAddr3, MemWData3, mem_rdata3;
    logic        CpuDone3, CpuStall3, ExtDone3, MemRE3, MemWE3;

    logic [15:0] mem [0:1023];
    int          n_pass = 0;
    int          n_total = 0;
    int          n_fail = 0;
    int          both_cnt = 0;
    int          got;
    logic        grant_ext [0:5];
    logic        exp_ext   [0:5];

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.MEM_LAT(1)) u_dut (
        .CLK(CLK), .Reset_n(Reset_n),
        .CpuRead(CpuRead), .CpuWrite(CpuWrite), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
        .CpuRData(CpuRData), .CpuDone(CpuDone), .CpuStall(CpuStall),
        .ExtReq(ExtReq), .ExtWE(ExtWE), .ExtAddr(ExtAddr), .ExtWData(ExtWData),
        .ExtRData(ExtRData), .ExtDone(ExtDone),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemRE(MemRE), .MemWE(MemWE),
        .MemRData(mem_rdata)
    );

    mem_port_arbiter #(.MEM_LAT(3)) u_dut3 (
        .CLK(CLK), .Reset_n(rst3_n),
        .CpuRead(CpuRead), .CpuWrite(CpuWrite), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
        .CpuRData(CpuRData3), .CpuDone(CpuDone3), .CpuStall(CpuStall3),
        .ExtReq(ExtReq), .ExtWE(ExtWE), .ExtAddr(ExtAddr), .ExtWData(ExtWData),
        .ExtRData(ExtRData3), .ExtDone(ExtDone3),
        .MemAddr(MemAddr3), .MemWData(MemWData3), .MemRE(MemRE3), .MemWE(MemWE3),
        .MemRData(mem_rdata3)
    );

    // Zero-wait memory model; data is stable while the registered address is held.
    assign mem_rdata  = mem[MemAddr[9:0]];
    assign mem_rdata3 = mem[MemAddr3[9:0]];

    always @(posedge CLK) begin
        if (MemWE) mem[MemAddr[9:0]] <= MemWData;
        if (MemRE && MemWE) both_cnt <= both_cnt + 1;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[10'h010] = 16'hA5C3;
        mem[10'h300] = 16'hBEEF;

        Reset_n = 1'b0; rst3_n = 1'b0;
        CpuRead = 1'b1; CpuWrite = 1'b0; CpuAddr = 16'h0010; CpuWData = 16'h0000;
        ExtReq = 1'b1; ExtWE = 1'b0; ExtAddr = 16'h0300; ExtWData = 16'h0000;
        step(); step();
        check("rst_re", 32'(MemRE), 32'd0);
        check("rst_we", 32'(MemWE), 32'd0);
        check("rst_stall", 32'(CpuStall), 32'd1);
        check("rst_done", 32'(CpuDone), 32'd0);
        check("rst_rdata", 32'(CpuRData), 32'h0);
        check("rst_addr", 32'(MemAddr), 32'h0);

        // Both requesting out of reset: CPU read of 0x0010 wins.
        Reset_n = 1'b1;
        step();
        check("fetch_re", 32'(MemRE), 32'd1);
        check("fetch_we", 32'(MemWE), 32'd0);
        check("fetch_addr", 32'(MemAddr), 32'h0010);
        check("fetch_stall", 32'(CpuStall), 32'd1);
        step();
        check("fetch_re_off", 32'(MemRE), 32'd0);
        check("fetch_done_early", 32'(CpuDone), 32'd0);
        step();
        check("fetch_done", 32'(CpuDone), 32'd1);
        check("fetch_rdata", 32'(CpuRData), 32'hA5C3);
        check("fetch_stall_off", 32'(CpuStall), 32'd0);

        // CPU releases; pending Ext read of 0x0300 is granted.
        CpuRead = 1'b0;
        step();
        check("ext_re", 32'(MemRE), 32'd1);
        check("ext_addr", 32'(MemAddr), 32'h0300);
        check("ext_cpu_done_off", 32'(CpuDone), 32'd0);
        CpuWrite = 1'b1; CpuAddr = 16'h0200; CpuWData = 16'h1234; ExtReq = 1'b0;
        #1;
        check("cpu_stall_during_ext", 32'(CpuStall), 32'd1);
        step();
        check("ext_done_early", 32'(ExtDone), 32'd0);
        check("ext_re_off", 32'(MemRE), 32'd0);
        step();
        check("ext_done", 32'(ExtDone), 32'd1);
        check("ext_rdata", 32'(ExtRData), 32'hBEEF);
        check("cpu_stall_wait", 32'(CpuStall), 32'd1);

        // CPU store 0x1234 -> 0x0200.
        step();
        check("st_we", 32'(MemWE), 32'd1);
        check("st_re", 32'(MemRE), 32'd0);
        check("st_wdata", 32'(MemWData), 32'h1234);
        check("st_addr", 32'(MemAddr), 32'h0200);
        check("st_ext_done_off", 32'(ExtDone), 32'd0);
        step();
        check("st_done", 32'(CpuDone), 32'd1);
        check("st_we_off", 32'(MemWE), 32'd0);
        check("st_stall_off", 32'(CpuStall), 32'd0);

        // External write 0x5A5A -> 0x0040.
        CpuWrite = 1'b0; ExtReq = 1'b1; ExtWE = 1'b1; ExtAddr = 16'h0040; ExtWData = 16'h5A5A;
        step();
        check("ew_we", 32'(MemWE), 32'd1);
        check("ew_addr", 32'(MemAddr), 32'h0040);
        check("ew_wdata", 32'(MemWData), 32'h5A5A);
        ExtReq = 1'b0; ExtWE = 1'b0;
        step();
        check("ew_done", 32'(ExtDone), 32'd1);

        // Read back the stored word.
        CpuRead = 1'b1; CpuAddr = 16'h0200;
        step();
        check("rb_re", 32'(MemRE), 32'd1);
        check("rb_addr", 32'(MemAddr), 32'h0200);
        step(); step();
        check("rb_done", 32'(CpuDone), 32'd1);
        check("rb_rdata", 32'(CpuRData), 32'h1234);
        check("rb_ext_rdata_held", 32'(ExtRData), 32'hBEEF);
        CpuRead = 1'b0;
        step(); step();

        // Continuous CPU reads with Ext pending: record the first six grants.
        CpuRead = 1'b1; CpuAddr = 16'h0010;
        ExtReq = 1'b1; ExtWE = 1'b0; ExtAddr = 16'h0300;
        got = 0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            step();
            if (MemRE || MemWE) begin
                grant_ext[got] = (MemAddr == 16'h0300);
                got++;
            end
        end
        check("guard_grant_count", 32'(got), 32'd6);
        for (int i = 0; i < 6; i++) exp_ext[i] = 1'b0;
`ifdef MEMARB_STARVE_GUARD_EN
        exp_ext[4] = 1'b1;
`endif
        for (int i = 0; i < 6 && i < got; i++) begin
            check($sformatf("guard_grant%0d_ext", i), 32'(grant_ext[i]), 32'(exp_ext[i]));
        end
        CpuRead = 1'b0; ExtReq = 1'b0;
        step(); step(); step(); step();
        check("strobes_exclusive", 32'(both_cnt), 32'd0);

        // MEM_LAT=3 instance: reset while waiting for read data.
        CpuRead = 1'b1; CpuAddr = 16'h0010;
        check("l3_rst_done", 32'(CpuDone3), 32'd0);
        check("l3_rst_ext", 32'({ExtDone3, MemWE3}), 32'd0);
        check("l3_rst_ext_rdata", 32'(ExtRData3), 32'h0);
        rst3_n = 1'b1;
        step();
        check("l3_grant_re", 32'(MemRE3), 32'd1);
        step(); step();
        rst3_n = 1'b0;
        step();
        check("l3_abort_re", 32'(MemRE3), 32'd0);
        check("l3_abort_done", 32'(CpuDone3), 32'd0);
        check("l3_abort_addr", 32'(MemAddr3), 32'h0);
        check("l3_abort_wdata", 32'(MemWData3), 32'h0);
        check("l3_abort_stall", 32'(CpuStall3), 32'd1);
        step();
        check("l3_abort_done2", 32'(CpuDone3), 32'd0);

        // Full MEM_LAT=3 read: Done four cycles after the grant.
        rst3_n = 1'b1;
        step();
        check("l3_re", 32'(MemRE3), 32'd1);
        step(); step(); step();
        check("l3_done_early", 32'(CpuDone3), 32'd0);
        step();
        check("l3_done", 32'(CpuDone3), 32'd1);
        check("l3_rdata", 32'(CpuRData3), 32'hA5C3);
        CpuRead = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port main memory between the multicycle control unit's memory port and an external requester (program loader / debug port).
- Sits between the control unit's MRead/MWrite/MAddr-selected address path and the memory block.
- Stalls the control unit while the memory is busy with the other requester.
- Sequences read latency and returns read data to whichever requester was granted.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 1, memory read latency in cycles (1..7), counted from the MemRE cycle to MemRData valid
- STARVE_MAX, 4, number of consecutive CPU grants while ExtReq is pending before Ext is forced (guard only)

Ports:
- CLK  in  1  system clock, rising edge
- Reset_n  in  1  synchronous active-low reset
- CpuRead  in  1  control-unit read request (level, held while stalled)
- CpuWrite  in  1  control-unit write request (level, held while stalled)
- CpuAddr  in  ADDR_W  CPU access address
- CpuWData  in  DATA_W  CPU write data
- CpuRData  out  DATA_W  CPU read data, valid while CpuDone=1, held after
- CpuDone  out  1  one-cycle pulse: CPU access complete
- CpuStall  out  1  freeze control-unit state and PCWrite
- ExtReq  in  1  external request (level)
- ExtWE  in  1  external write (1) / read (0)
- ExtAddr  in  ADDR_W  external address
- ExtWData  in  DATA_W  external write data
- ExtRData  out  DATA_W  external read data, valid while ExtDone=1, held after
- ExtDone  out  1  one-cycle pulse: external access complete
- MemAddr  out  ADDR_W  memory address (registered)
- MemWData  out  DATA_W  memory write data (registered)
- MemRE  out  1  memory read strobe, one cycle
- MemWE  out  1  memory write strobe, one cycle
- MemRData  in  DATA_W  memory read data

Behaviour:
- Reset (Reset_n=0 at an edge): state=IDLE; all strobes, Done pulses and the starve counter clear to 0; CpuRData/ExtRData=0; MemAddr/MemWData=0. Reset mid-access aborts the access with no Done pulse, and MemRE/MemWE are 0 from the next edge.
- CpuReq = CpuRead | CpuWrite. If both are set, the access is a write.
- Combinational stall: CpuStall = CpuReq & ~CpuDone.
- FSM states: IDLE, CPU_ACC, EXT_ACC, CPU_RWAIT, EXT_RWAIT.
- IDLE arbitration on an edge:
  - Only CpuReq: grant CPU.
  - Only ExtReq: grant Ext.
  - Both: CPU wins, unless the guard forces Ext.
  - On grant: register MemAddr/MemWData from the winner, assert exactly one of MemRE/MemWE for exactly one cycle, and go to the *_ACC state.
- *_ACC (strobe cycle):
  - Write: next edge returns to IDLE and pulses the Done of that requester for one cycle. Total = 2 cycles from request seen in IDLE.
  - Read: load latency counter = MEM_LAT-1, go to *_RWAIT.
- *_RWAIT:
  - Decrement the counter each cycle.
  - When the counter is 0: capture MemRData into CpuRData/ExtRData, pulse Done, return to IDLE.
  - CPU read total = MEM_LAT+1 cycles after grant.
- Back-to-back: Done cycle coincides with the IDLE cycle, so a held request is re-arbitrated on that edge. The control unit must deassert its request or change state on CpuDone.
- ExtReq dropped mid-access: the access still completes and ExtDone still pulses. Requester inputs are sampled only at the grant edge.
- MemRE and MemWE are never both 1. No strobe is issued outside the *_ACC states.

Optional Feature:
- Macro: MEMARB_STARVE_GUARD_EN.
- Defined:
  - A 3-bit counter increments on each CPU grant made while ExtReq=1, saturating at STARVE_MAX.
  - It clears on any Ext grant, or when ExtReq=0 in IDLE.
  - When the counter equals STARVE_MAX and both requests are present, Ext is granted.
- Undefined: strict CPU priority, and no counter is present.

Test Plan:
- Reset with CpuRead=1, ExtReq=1 held low-reset 2 cycles -> MemRE=MemWE=0, CpuStall=1, CpuDone=0, CpuRData=0; first grant after release goes to CPU.
- CPU fetch, MEM_LAT=1: CpuRead=1, CpuAddr=16'h0010, MemRData=16'hA5C3 -> MemRE=1 one cycle with MemAddr=16'h0010; CpuDone=1 and CpuRData=16'hA5C3 two cycles after grant; CpuStall=0 that cycle.
- CPU store: CpuWrite=1, CpuAddr=16'h0200, CpuWData=16'h1234 -> MemWE=1 for one cycle, MemWData=16'h1234; CpuDone pulses next cycle.
- Contention: ExtReq=1 (read, 16'h0300) during a CPU read -> the CPU access completes uninterrupted; Ext is granted on the next IDLE edge when CpuReq=0; CpuStall=1 throughout if the CPU re-requests.
- Guard (MEMARB_STARVE_GUARD_EN, STARVE_MAX=4): CPU requests continuously, ExtReq=1 -> exactly 4 CPU accesses, then 1 Ext access, then CPU resumes. Without the macro, Ext is never granted.
- Reset at CPU_RWAIT with MEM_LAT=3 -> no CpuDone pulse, state IDLE, MemRE=0 next edge.
